// File: rtl/vproc_pipe_receiver_if.sv
// Dispatch and operation handshake bundle between the dispatcher, the pipeline
// receiver and the execution pipeline it feeds.
interface vproc_pipe_receiver_if #(
    parameter int  MAX_VADDR_W    = 5,
    parameter int  BEATS_PER_VREG = 4,
    parameter type DECODER_DATA_T = logic
);
    localparam int VADDR_CNT = 1 << MAX_VADDR_W;
    localparam int BEAT_W    = (BEATS_PER_VREG > 1) ? $clog2(BEATS_PER_VREG) : 1;

    logic                   dispatch_valid_i;
    logic                   dispatch_ready_o;
    DECODER_DATA_T          dispatch_data_i;
    logic [VADDR_CNT-1:0]   dispatch_vreg_wr_i;

    logic                   op_valid_o;
    logic                   op_ready_i;
    DECODER_DATA_T          op_data_o;
    logic [MAX_VADDR_W-1:0] op_vreg_o;
    logic [BEAT_W-1:0]      op_beat_o;
    logic                   op_first_o;
    logic                   op_last_o;
    logic                   op_nowr_o;

    modport master (
        output dispatch_valid_i, dispatch_data_i, dispatch_vreg_wr_i, op_ready_i,
        input  dispatch_ready_o, op_valid_o, op_data_o, op_vreg_o, op_beat_o,
               op_first_o, op_last_o, op_nowr_o
    );

    modport slave (
        input  dispatch_valid_i, dispatch_data_i, dispatch_vreg_wr_i, op_ready_i,
        output dispatch_ready_o, op_valid_o, op_data_o, op_vreg_o, op_beat_o,
               op_first_o, op_last_o, op_nowr_o
    );
endinterface

// File: rtl/vproc_pipe_receiver.sv
// Buffers dispatched vector instructions in order and sequences each into
// per-vreg, per-beat operations, returning a pending-write clear per finished vreg.
module vproc_pipe_receiver #(
    parameter int  MAX_VADDR_W    = 5,
    parameter int  BUF_DEPTH      = 2,
    parameter int  BEATS_PER_VREG = 4,
    parameter type DECODER_DATA_T = logic,
    parameter bit  DONT_CARE_ZERO = 1'b0
) (
    input  logic                          clk_i,
    input  logic                          async_rst_ni,
    input  logic                          sync_rst_ni,
    vproc_pipe_receiver_if.slave          pipe_if,
    output logic [(1<<MAX_VADDR_W)-1:0]   pend_vreg_wr_clear_o,
    output logic                          busy_o
);
    localparam int VADDR_CNT = 1 << MAX_VADDR_W;
    localparam int BEAT_W    = (BEATS_PER_VREG > 1) ? $clog2(BEATS_PER_VREG) : 1;
    localparam int PTR_W     = $clog2(BUF_DEPTH);
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_VREG - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(BUF_DEPTH);

    DECODER_DATA_T          r_bufData [BUF_DEPTH];
    logic [VADDR_CNT-1:0]   r_bufMap  [BUF_DEPTH];
    logic [PTR_W-1:0]       r_wrPtr;
    logic [PTR_W-1:0]       r_rdPtr;
    logic [CNT_W-1:0]       r_cnt;
    logic [VADDR_CNT-1:0]   r_done;
    logic [BEAT_W-1:0]      r_beat;
    logic [VADDR_CNT-1:0]   r_clear;

    logic [VADDR_CNT-1:0]   w_headMap;
    logic [VADDR_CNT-1:0]   w_rem;
    logic [MAX_VADDR_W-1:0] w_curIdx;
    logic [VADDR_CNT-1:0]   w_curOnehot;
    logic                   w_nowr;
    logic                   w_lastVreg;
    logic                   w_lastBeat;
    logic                   w_valid;
    logic                   w_ready;
    logic                   w_push;
    logic                   w_accept;
    logic                   w_pop;
    logic                   w_zero;

    // Ready depends on occupancy only, so a full queue refuses even in a pop cycle.
    assign w_ready  = (r_cnt != FULL_CNT);
    assign w_valid  = (r_cnt != '0);
    assign w_push   = pipe_if.dispatch_valid_i & w_ready;
    assign w_accept = w_valid & pipe_if.op_ready_i;

    assign w_headMap   = r_bufMap[r_rdPtr];
    assign w_rem       = w_headMap & ~r_done;
    assign w_nowr      = (w_headMap == '0);
    assign w_curOnehot = VADDR_CNT'(1) << w_curIdx;
    assign w_lastVreg  = ((w_rem & ~w_curOnehot) == '0);
    assign w_lastBeat  = (r_beat == LAST_BEAT);
    assign w_pop       = w_accept & w_lastBeat & w_lastVreg;

    always_comb begin
        w_curIdx = '0;
        for (int i = VADDR_CNT - 1; i >= 0; i--) begin
            if (w_rem[i]) begin
                w_curIdx = MAX_VADDR_W'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_bufData[r_wrPtr] <= pipe_if.dispatch_data_i;
            r_bufMap[r_wrPtr]  <= pipe_if.dispatch_vreg_wr_i;
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_cnt   <= '0;
            r_done  <= '0;
            r_beat  <= '0;
            r_clear <= '0;
        end else if (!sync_rst_ni) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_cnt   <= '0;
            r_done  <= '0;
            r_beat  <= '0;
            r_clear <= '0;
        end else begin
            r_clear <= '0;
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            // A vreg completes on its final beat; the instruction retires with its last vreg.
            if (w_accept) begin
                if (!w_lastBeat) begin
                    r_beat <= r_beat + BEAT_W'(1);
                end else begin
                    r_beat <= '0;
                    if (!w_nowr) begin
                        r_clear <= w_curOnehot;
                    end
                    if (w_lastVreg) begin
                        r_done <= '0;
                    end else begin
                        r_done <= r_done | w_curOnehot;
                    end
                end
            end
        end
    end

    assign w_zero = DONT_CARE_ZERO && !w_valid;

    always_comb begin
        pipe_if.op_data_o  = r_bufData[r_rdPtr];
        pipe_if.op_vreg_o  = w_curIdx;
        pipe_if.op_beat_o  = r_beat;
        pipe_if.op_first_o = (r_beat == '0) && (r_done == '0);
        pipe_if.op_last_o  = w_lastVreg && w_lastBeat;
        pipe_if.op_nowr_o  = w_nowr;
        if (w_zero) begin
            pipe_if.op_data_o  = DECODER_DATA_T'(0);
            pipe_if.op_vreg_o  = '0;
            pipe_if.op_beat_o  = '0;
            pipe_if.op_first_o = 1'b0;
            pipe_if.op_last_o  = 1'b0;
            pipe_if.op_nowr_o  = 1'b0;
        end
    end

    assign pipe_if.dispatch_ready_o = w_ready;
    assign pipe_if.op_valid_o       = w_valid;
    assign pend_vreg_wr_clear_o     = r_clear;
    assign busy_o                   = w_valid;

endmodule

// File: tb/tb_vproc_pipe_receiver.sv
// Scoreboard bench: each accepted dispatch expands into its expected beat list,
// which is checked against the operation port cycle by cycle.
module tb_vproc_pipe_receiver;
    localparam int DEPTH = 2;

    typedef struct {
        logic [7:0]  data;
        logic [4:0]  vreg;
        logic [1:0]  beat;
        logic        first;
        logic        last;
        logic        nowr;
        logic [31:0] clr;
    } expBeat_t;

    logic        clk;
    logic        asyncRstN;
    logic        syncRstN;
    logic [31:0] pendClear;
    logic        busy;

    int          vectorCount = 0;
    int          failCount   = 0;
    int          readyMode   = 0;
    int          modelCnt    = 0;
    logic [31:0] expClear    = '0;
    logic [7:0]  nextId      = 8'h10;
    expBeat_t    sb[$];

    vproc_pipe_receiver_if #(
        .MAX_VADDR_W(5), .BEATS_PER_VREG(4), .DECODER_DATA_T(logic [7:0])
    ) pipeIf ();

    vproc_pipe_receiver #(
        .MAX_VADDR_W(5), .BUF_DEPTH(DEPTH), .BEATS_PER_VREG(4),
        .DECODER_DATA_T(logic [7:0]), .DONT_CARE_ZERO(1'b1)
    ) dut (
        .clk_i(clk),
        .async_rst_ni(asyncRstN),
        .sync_rst_ni(syncRstN),
        .pipe_if(pipeIf),
        .pend_vreg_wr_clear_o(pendClear),
        .busy_o(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic pushExpected(input logic [31:0] map, input logic [7:0] data);
        expBeat_t e;
        int       n = 0;
        for (int v = 0; v < 32; v++) begin
            if (map[v]) begin
                for (int b = 0; b < 4; b++) begin
                    e.data  = data;
                    e.vreg  = 5'(v);
                    e.beat  = 2'(b);
                    e.first = (n == 0);
                    e.last  = 1'b0;
                    e.nowr  = 1'b0;
                    e.clr   = (b == 3) ? (32'h1 << v) : 32'h0;
                    sb.push_back(e);
                    n++;
                end
            end
        end
        if (map == 32'h0) begin
            for (int b = 0; b < 4; b++) begin
                e.data  = data;
                e.vreg  = '0;
                e.beat  = 2'(b);
                e.first = (b == 0);
                e.last  = 1'b0;
                e.nowr  = 1'b1;
                e.clr   = 32'h0;
                sb.push_back(e);
            end
        end
        sb[sb.size() - 1].last = 1'b1;
    endtask

    // Drives one dispatch from just after a rising edge and holds it until accepted.
    task automatic applyStimulus(input logic [31:0] map);
        logic accepted = 1'b0;
        pipeIf.dispatch_valid_i   = 1'b1;
        pipeIf.dispatch_vreg_wr_i = map;
        pipeIf.dispatch_data_i    = nextId;
        nextId++;
        for (int c = 0; c < 200 && !accepted; c++) begin
            @(negedge clk);
            if (pipeIf.dispatch_ready_o) accepted = 1'b1;
        end
        @(posedge clk);
        #1;
        pipeIf.dispatch_valid_i = 1'b0;
        checkOutput("dispatchAccepted", accepted, 1'b1);
    endtask

    task automatic waitIdle();
        logic idle = 1'b0;
        for (int c = 0; c < 1000 && !idle; c++) begin
            @(negedge clk);
            if (modelCnt == 0 && sb.size() == 0 && !busy) idle = 1'b1;
        end
        @(posedge clk);
        #1;
        checkOutput("drainIdle", idle, 1'b1);
    endtask

    initial begin
        pipeIf.op_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       pipeIf.op_ready_i = 1'b1;
                1:       pipeIf.op_ready_i = ~pipeIf.op_ready_i;
                2:       pipeIf.op_ready_i = 1'b0;
                default: pipeIf.op_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Model step per cycle: compare against the scoreboard head, then apply this edge's pop/push.
    initial begin
        int cntNow;
        forever begin
            @(negedge clk);
            if (!asyncRstN) begin
                sb.delete();
                modelCnt = 0;
                expClear = '0;
                checkOutput("rstValid", pipeIf.op_valid_o, 1'b0);
                checkOutput("rstReady", pipeIf.dispatch_ready_o, 1'b1);
                checkOutput("rstBusy", busy, 1'b0);
                checkOutput("rstClear", pendClear, 32'h0);
                checkOutput("rstData", pipeIf.op_data_o, 8'h0);
            end else begin
                cntNow = modelCnt;
                checkOutput("clear", pendClear, expClear);
                expClear = '0;
                checkOutput("ready", pipeIf.dispatch_ready_o, cntNow != DEPTH);
                checkOutput("busy", busy, cntNow != 0);
                checkOutput("valid", pipeIf.op_valid_o, sb.size() != 0);
                if (pipeIf.op_valid_o && sb.size() != 0) begin
                    checkOutput("opData", pipeIf.op_data_o, sb[0].data);
                    checkOutput("opVreg", pipeIf.op_vreg_o, sb[0].vreg);
                    checkOutput("opBeat", pipeIf.op_beat_o, sb[0].beat);
                    checkOutput("opFirst", pipeIf.op_first_o, sb[0].first);
                    checkOutput("opLast", pipeIf.op_last_o, sb[0].last);
                    checkOutput("opNowr", pipeIf.op_nowr_o, sb[0].nowr);
                    if (pipeIf.op_ready_i) begin
                        expClear = sb[0].clr;
                        if (sb[0].last) modelCnt--;
                        void'(sb.pop_front());
                    end
                end else if (!pipeIf.op_valid_o) begin
                    checkOutput("idleData", pipeIf.op_data_o, 8'h0);
                end
                if (pipeIf.dispatch_valid_i && cntNow != DEPTH) begin
                    pushExpected(pipeIf.dispatch_vreg_wr_i, pipeIf.dispatch_data_i);
                    modelCnt++;
                end
                if (!syncRstN) begin
                    sb.delete();
                    modelCnt = 0;
                    expClear = '0;
                end
            end
        end
    end

    initial begin
        logic [31:0] map;
        asyncRstN = 1'b0;
        syncRstN  = 1'b1;
        pipeIf.dispatch_valid_i   = 1'b0;
        pipeIf.dispatch_vreg_wr_i = '0;
        pipeIf.dispatch_data_i    = '0;
        repeat (3) @(posedge clk);
        #1 asyncRstN = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] two-vreg instruction");
        applyStimulus(32'h0000_0006);
        waitIdle();

        $display("[TB] backpressure");
        readyMode = 1;
        applyStimulus(32'h0000_0006);
        waitIdle();
        readyMode = 0;

        $display("[TB] full queue");
        readyMode = 2;
        #10;
        applyStimulus(32'h0000_0001);
        applyStimulus(32'h0000_0008);
        fork
            applyStimulus(32'h0000_0010);
            begin
                repeat (4) @(negedge clk);
                readyMode = 0;
            end
        join
        waitIdle();

        $display("[TB] no-write and back-to-back");
        applyStimulus(32'h0000_0000);
        waitIdle();
        applyStimulus(32'h0000_0003);
        applyStimulus(32'h8000_0000);
        applyStimulus(32'h0000_0000);
        waitIdle();

        $display("[TB] async reset mid-instruction");
        applyStimulus(32'h0000_0006);
        @(posedge clk);
        @(posedge clk);
        #1 asyncRstN = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 asyncRstN = 1'b1;
        waitIdle();

        $display("[TB] sync reset mid-instruction");
        applyStimulus(32'h0000_0018);
        repeat (3) @(posedge clk);
        #1 syncRstN = 1'b0;
        @(posedge clk);
        #1 syncRstN = 1'b1;
        waitIdle();

        $display("[TB] random traffic");
        readyMode = 3;
        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(0, 3))
                0:       map = 32'h0;
                1:       map = 32'h1 << $urandom_range(0, 31);
                default: map = (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
            endcase
            applyStimulus(map);
        end
        waitIdle();
        readyMode = 0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end

endmodule

// File: doc/vproc_pipe_receiver.md
# vproc_pipe_receiver

Pipeline-side receiving end of the dispatch interface. It accepts dispatched vector instructions through a valid/ready handshake and buffers them in a small in-order queue. It sequences each instruction into per-register, per-beat operations for the execution pipeline. When the last beat of each destination register has been handed off, it returns a one-cycle pending-write clear for that register to the dispatcher's hazard map. One instance sits in front of each execution pipeline.

## Interface
- `MAX_VADDR_W`, default 5: max vreg address width; `VADDR_CNT = 1<<MAX_VADDR_W`.
- `BUF_DEPTH`, default 2: instruction queue depth; power of two, ≥2.
- `BEATS_PER_VREG`, default 4: operation beats per destination vreg; ≥1; `BEAT_W = max(1, $clog2(BEATS_PER_VREG))`.
- `DECODER_DATA_T`, default `logic`: decoded instruction payload type, carried opaquely.
- `DONT_CARE_ZERO`, default 0: when 1, op payload outputs are driven to zero while `op_valid_o` is low.

Ports:
- `clk_i`  in  1  sole clock.
- `async_rst_ni`  in  1  asynchronous, active-low reset.
- `sync_rst_ni`  in  1  synchronous active-low clear; same effect as reset, applied at the clock edge.
- `dispatch_valid_i`  in  1  instruction offered.
- `dispatch_ready_o`  out  1  queue can accept.
- `dispatch_data_i`  in  DECODER_DATA_T  decoded instruction.
- `dispatch_vreg_wr_i`  in  VADDR_CNT  destination vreg map of the offered instruction.
- `op_valid_o`  out  1  operation beat valid.
- `op_ready_i`  in  1  pipeline accepts beat.
- `op_data_o`  out  DECODER_DATA_T  head instruction payload.
- `op_vreg_o`  out  MAX_VADDR_W  current destination vreg.
- `op_beat_o`  out  BEAT_W  beat index within the vreg.
- `op_first_o`  out  1  first beat of the instruction.
- `op_last_o`  out  1  last beat of the instruction.
- `op_nowr_o`  out  1  instruction writes no vreg.
- `pend_vreg_wr_clear_o`  out  VADDR_CNT  one-cycle clear pulses, registered.
- `busy_o`  out  1  queue non-empty.

## Operation
- **Queue.** Circular FIFO with fields {data, vreg map}, read/write pointers, and occupancy `cnt` (0..BUF_DEPTH).
  - Push on `dispatch_valid_i & dispatch_ready_o`.
  - `dispatch_ready_o = (cnt != BUF_DEPTH)`, derived from registers only. There is no combinational path from `op_ready_i` or `dispatch_valid_i`, so a full queue refuses a push even in a pop cycle.
- **Head sequencing.** Registers `done_q` (VADDR_CNT) and `beat_q` (BEAT_W).
  - `rem = head_map & ~done_q`.
  - `cur` = lowest set bit of `rem`; `op_vreg_o` = its index.
  - `last_vreg = (rem & ~onehot(cur)) == 0`.
  - Empty `head_map`: `op_vreg_o = 0`, `op_nowr_o = 1`, `last_vreg = 1`.
- **Beat outputs.**
  - `op_valid_o = (cnt != 0)`.
  - `op_first_o = (beat_q == 0) & (done_q == 0)`.
  - `op_last_o = last_vreg & (beat_q == BEATS_PER_VREG-1)`.
- **On an accepted beat** (`op_valid_o & op_ready_i`):
  - If not the last beat of the vreg: `beat_q++`.
  - If it is the last beat of the vreg: `beat_q <= 0`; `done_q |= onehot(cur)`; `pend_vreg_wr_clear_o <= onehot(cur)` next cycle. No clear is issued when `op_nowr_o` is set.
  - If `op_last_o` is also set: pop the head and set `done_q <= 0`.
- `pend_vreg_wr_clear_o` is zero in every cycle not following a vreg completion. At most one bit is set per cycle.
- **Simultaneous push and pop:** `cnt` is unchanged, pointers both advance, and wrap-around is modulo BUF_DEPTH.
- **Stalls:** all op outputs hold stable while `op_valid_o & ~op_ready_i`.
- **Reset.** `async_rst_ni` low or `sync_rst_ni` low:
  - Clears `cnt`, pointers, `done_q`, `beat_q` and `pend_vreg_wr_clear_o`.
  - Buffered instructions are dropped and no clear pulses are emitted for them.
  - Reset values: `dispatch_ready_o=1`, `op_valid_o=0`, `busy_o=0`, `clear=0`. Payload outputs are 0 when `DONT_CARE_ZERO`, otherwise don't-care.

## Timing
- Instruction accepted at edge N is presented on `op_valid_o` from cycle N+1 at the earliest. The queue is not bypassed.
- Throughput is one beat per cycle. Back-to-back instructions issue with no bubble: the next head beat follows the popping beat directly.
- An instruction writing k vregs takes `max(1,k)*BEATS_PER_VREG` accepted beats.
- A clear pulse appears exactly one cycle after the handshake of a vreg's final beat and lasts one cycle.
- The dispatcher sets its pending bit at the dispatch handshake, so every clear arrives at least two cycles after the matching set.

## Test plan
1. **Reset:** hold `async_rst_ni=0` -> `dispatch_ready_o=1`, `op_valid_o=0`, `busy_o=0`, `clear=0`. Release with no traffic -> outputs unchanged.
2. **Two-vreg instruction:** map `0x00000006`, B=4, `op_ready_i=1`, accepted at N -> beats vreg1/0..3 in cycles N+1..N+4, then vreg2/0..3 in N+5..N+8. Clear `0x2` at N+5 and `0x4` at N+9. `op_first_o` at N+1, `op_last_o` at N+8.
3. **Backpressure:** same instruction with `op_ready_i` alternating 0/1 -> outputs stable during stalls, 8 accepted beats in order, each clear one cycle after its final accepted beat only.
4. **Full queue:** `op_ready_i=0`, dispatch maps `0x1`, `0x8`, `0x10` -> first two accepted, third held with `dispatch_ready_o=0`. Release `op_ready_i` -> order v0, v3, v4, no bubbles; third accepted the cycle after the first pop.
5. **No-write instruction:** map `0` -> 4 beats with `op_nowr_o=1`, `op_vreg_o=0`, no clear pulse.
6. **Reset mid-instruction:** assert `async_rst_ni=0` during beat 2 of vreg1 -> immediate `op_valid_o=0`. No clear emitted for vreg1, queue empty after release.
